reverse_stream: RTL
===================

// Module: reverse_stream
// PURPOSE
//  Streaming, mode-selectable bit/group reverser with valid/ready handshake on both sides.
//  Generalises the combinational bit reverser: runtime mode, configurable group size,
//  registered output behind a 2-entry buffer, and an output transfer counter.
//  Sits between a producer and consumer stream. Applies full backpressure and never drops a word.
// PARAMETERS
//  DATA_WIDTH   32  word width in bits
//  GROUP_WIDTH  8   group size for modes 2/3. DATA_WIDTH % GROUP_WIDTH != 0 -> $error at elaboration.
//  CNT_WIDTH    16  width of xfer_count
// PORTS
//  clk          in   1           clock, rising edge
//  reset        in   1           asynchronous reset, active-high
//  din          in   DATA_WIDTH  input word
//  din_mode     in   2           transform for this word, sampled with din
//  din_valid    in   1           producer has a word
//  din_ready    out  1           block can accept a word
//  dout         out  DATA_WIDTH  transformed word (head of buffer)
//  dout_valid   out  1           dout holds a valid word
//  dout_ready   in   1           consumer accepts dout
//  xfer_count   out  CNT_WIDTH   number of completed output transfers, mod 2^CNT_WIDTH
// BEHAVIOUR
//  Modes (G = DATA_WIDTH/GROUP_WIDTH groups; group k = bits [k*GW +: GW]):
//   0 PASS:  dout = din
//   1 BITREV: dout[i] = din[DATA_WIDTH-1-i]
//   2 GRPREV: group k of dout = group G-1-k of din (byte swap when GW=8). Bit order inside a group is kept.
//   3 INGRP:  each group is bit-reversed in place. Group order is kept.
//  The transform is applied at acceptance. The buffer stores transformed words.
//  din_mode is captured only on push, so a later mode change never affects stored words.
//  Push = din_valid & din_ready. Pop = dout_valid & dout_ready.
//  Buffer: 2-entry in-order FIFO with occupancy cnt in {0,1,2}. States EMPTY(0), ONE(1), FULL(2).
//   din_ready  = (cnt != 2), derived from registered state only. No comb path from dout_ready.
//   dout_valid = (cnt != 0). dout = oldest entry. dout is held stable while dout_valid & !dout_ready.
//   EMPTY: push -> ONE.
//   ONE:   push & !pop -> FULL. pop & !push -> EMPTY. push & pop -> ONE, head <= new word.
//   FULL:  pop -> ONE. No push is possible.
//  Latency: a word pushed at edge t is on dout with dout_valid=1 after edge t (1 cycle).
//  Throughput: 1 word/cycle sustained while dout_ready=1.
//  The din_valid=1, din_ready=0 case (FULL) is legal. The producer holds its word, nothing is lost.
//  din_valid=0 -> din and din_mode are ignored (may be X).
//  xfer_count increments by 1 on each pop and wraps from all-ones to 0.
//  Reset (async assert, takes effect immediately, mid-transfer included):
//   cnt=0, dout_valid=0, din_ready=1 after deassert, xfer_count=0, dout=0, buffer contents=0.
//   Words in flight are discarded.
//  After reset deassert, the first push is permitted on the first rising edge.
// TESTING (DATA_WIDTH=32, GROUP_WIDTH=8, CNT_WIDTH=16)
//  1 Modes, dout_ready=1:
//    0x12345678 m0 -> 0x12345678
//    0x00000001 m1 -> 0x80000000
//    0x12345678 m2 -> 0x78563412
//    0x01020304 m3 -> 0x8040C020
//    each appears 1 cycle after push.
//  2 Backpressure: hold dout_ready=0 and offer 3 words A,B,C.
//    -> A and B accepted, din_ready=0 with C held.
//    -> release dout_ready: A, B, C emerge in order. No loss, no duplicates.
//  3 Simultaneous push/pop at cnt=1 for 10 cycles -> one word/cycle out.
//    cnt stays 1, xfer_count advances by 10.
//  4 Mode change while a word is stored (push m1, then set din_mode=0 before pop).
//    -> stored word still shows the m1 result.
//  5 Assert reset with cnt=2 and dout_valid=1.
//    -> dout_valid=0 and xfer_count=0 in the same cycle, without a clock edge.
//    After release, din_ready=1.
//  6 Wrap: 65537 pops -> xfer_count=1. Random valid/ready stress vs reference model: zero mismatches.

Source files
------------

// File: rtl/reverse_stream.sv
// ============================================================================
// Module   : reverse_stream
// Brief    : Streaming bit/group reverser with a 2-entry output buffer,
//            valid/ready handshake on both sides and an output transfer count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reverse_stream #(
    parameter int DATA_WIDTH  = 32,
    parameter int GROUP_WIDTH = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [1:0]            din_mode,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [CNT_WIDTH-1:0]  xfer_count
);

    localparam int c_groups = DATA_WIDTH / GROUP_WIDTH;

    localparam logic [1:0] c_empty = 2'd0;
    localparam logic [1:0] c_one   = 2'd1;
    localparam logic [1:0] c_full  = 2'd2;

    localparam logic [1:0] c_mode_pass   = 2'd0;
    localparam logic [1:0] c_mode_bitrev = 2'd1;
    localparam logic [1:0] c_mode_grprev = 2'd2;
    localparam logic [1:0] c_mode_ingrp  = 2'd3;

    generate
        if (DATA_WIDTH % GROUP_WIDTH != 0) begin : g_width_check
            $error("reverse_stream: DATA_WIDTH must be a multiple of GROUP_WIDTH");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] w_bitrev;
    logic [DATA_WIDTH-1:0] w_grprev;
    logic [DATA_WIDTH-1:0] w_ingrp;
    logic [DATA_WIDTH-1:0] w_xform;
    logic                  w_push;
    logic                  w_pop;

    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic [CNT_WIDTH-1:0]  r_xfer;

    generate
        for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bitrev
            assign w_bitrev[i] = din[DATA_WIDTH-1-i];
        end

        for (genvar k = 0; k < c_groups; k++) begin : g_group
            assign w_grprev[k*GROUP_WIDTH +: GROUP_WIDTH] =
                din[(c_groups-1-k)*GROUP_WIDTH +: GROUP_WIDTH];
            for (genvar j = 0; j < GROUP_WIDTH; j++) begin : g_ingrp
                assign w_ingrp[k*GROUP_WIDTH + j] = din[k*GROUP_WIDTH + GROUP_WIDTH-1-j];
            end
        end
    endgenerate

    always_comb begin
        w_xform = din;
        case (din_mode)
            c_mode_pass:   w_xform = din;
            c_mode_bitrev: w_xform = w_bitrev;
            c_mode_grprev: w_xform = w_grprev;
            c_mode_ingrp:  w_xform = w_ingrp;
            default:       w_xform = din;
        endcase
    end

    // Handshake flags come from registered state only, so din_ready never
    // depends combinationally on dout_ready.
    assign din_ready  = (r_state != c_full);
    assign dout_valid = (r_state != c_empty);
    assign dout       = r_head;
    assign xfer_count = r_xfer;

    assign w_push = din_valid & din_ready;
    assign w_pop  = dout_valid & dout_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_empty;
            r_head  <= '0;
            r_tail  <= '0;
            r_xfer  <= '0;
        end else begin
            if (w_pop) begin
                r_xfer <= r_xfer + CNT_WIDTH'(1);
            end
            case (r_state)
                c_empty: begin
                    if (w_push) begin
                        r_head  <= w_xform;
                        r_state <= c_one;
                    end
                end
                c_one: begin
                    if (w_push && !w_pop) begin
                        r_tail  <= w_xform;
                        r_state <= c_full;
                    end else if (w_pop && !w_push) begin
                        r_state <= c_empty;
                    end else if (w_push && w_pop) begin
                        r_head  <= w_xform;
                    end
                end
                c_full: begin
                    if (w_pop) begin
                        r_head  <= r_tail;
                        r_state <= c_one;
                    end
                end
                default: begin
                    r_state <= c_empty;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
